wash_panel_interface: RTL and testbench

//  Front-panel initiator for the washing machine controller. Debounces the raw coin, double-wash and

---
 rtl/wm_pkg.sv | 15 +
 rtl/wm_debounce.sv | 44 ++++
 rtl/wash_panel_interface.sv | 148 ++++++++++++++
 tb/tb_wash_panel_interface.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine front panel and controller:
// FSM state encodings and default pricing.
package wm_pkg;

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_START   = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_CREDIT_W        = 4;
  localparam int DEF_WASH_PRICE      = 2;
  localparam int DEF_DOUBLE_PRICE    = 3;

endpackage

// File: rtl/wm_debounce.sv
// Switch conditioner: 2-flop synchronizer, stable-sample counter and a
// one-cycle pulse on each debounced rising edge.
module wm_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic [CW-1:0] cnt_reg;

  // The counter tracks consecutive samples that disagree with the current level;
  // a single agreeing sample (bounce) restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      cnt_reg   <= '0;
      level     <= 1'b0;
      rise      <= 1'b0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      rise      <= 1'b0;
      if (sync2_reg == level) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
        level   <= sync2_reg;
        rise    <= sync2_reg;
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

endmodule

// File: rtl/wash_panel_interface.sv
// Front-panel initiator: debounces coin/selector/pause switches, accumulates credit and
// launches washes. Optional coin refund is compiled in with `define REFUND_EN.
module wash_panel_interface
  import wm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CREDIT_W        = DEF_CREDIT_W,
  parameter int WASH_PRICE      = DEF_WASH_PRICE,
  parameter int DOUBLE_PRICE    = DEF_DOUBLE_PRICE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_sw_raw,
  input  logic                double_sw_raw,
  input  logic                pause_btn_raw,
`ifdef REFUND_EN
  input  logic                refund_btn_raw,
  output logic                coin_return,
`endif
  input  logic                wash_done,
  output logic                coin_in,
  output logic                double_wash,
  output logic                timer_pause,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;

  logic coin_level, coin_rise, dbl_level, dbl_rise, pause_level, pause_rise;
  logic refund_active, refund_tick;

  logic [1:0]          state_reg, state_next;
  logic [CREDIT_W-1:0] credit_reg, credit_next;
  logic                double_wash_reg, double_wash_next;
  logic                timer_pause_reg, timer_pause_next;
  logic                busy_reg, busy_next;
  logic [CREDIT_W-1:0] price;

  wm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_coin (
    .clk(clk), .rst_n(rst_n), .raw(coin_sw_raw), .level(coin_level), .rise(coin_rise));
  wm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbl (
    .clk(clk), .rst_n(rst_n), .raw(double_sw_raw), .level(dbl_level), .rise(dbl_rise));
  wm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
    .clk(clk), .rst_n(rst_n), .raw(pause_btn_raw), .level(pause_level), .rise(pause_rise));

`ifdef REFUND_EN
  logic       refund_level, refund_rise;
  logic       refund_active_reg;
  logic [1:0] refund_phase_reg;

  wm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_refund (
    .clk(clk), .rst_n(rst_n), .raw(refund_btn_raw), .level(refund_level), .rise(refund_rise));

  assign refund_active = refund_active_reg;
  assign refund_tick   = refund_active_reg && (refund_phase_reg == 2'd3) && (credit_reg != '0);
  assign coin_return   = refund_tick;

  // Refund keeps running until a tick leaves no credit, so coins arriving mid-refund are paid back too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refund_active_reg <= 1'b0;
      refund_phase_reg  <= 2'd0;
    end else if (!refund_active_reg) begin
      if (state_reg == S_COLLECT && refund_rise) begin
        refund_active_reg <= 1'b1;
        refund_phase_reg  <= 2'd0;
      end
    end else begin
      refund_phase_reg <= refund_phase_reg + 2'd1;
      if (refund_phase_reg == 2'd3 && credit_next == '0) refund_active_reg <= 1'b0;
    end
  end
`else
  assign refund_active = 1'b0;
  assign refund_tick   = 1'b0;
`endif

  // Debounced levels/edges that the panel logic has no use for.
  logic unused_levels;
  assign unused_levels = ^{coin_level, dbl_rise, pause_level
`ifdef REFUND_EN
                           , refund_level
`endif
                          };

  assign price = dbl_level ? CREDIT_W'(DOUBLE_PRICE) : CREDIT_W'(WASH_PRICE);

  always_comb begin
    state_next       = state_reg;
    credit_next      = credit_reg;
    double_wash_next = double_wash_reg;
    timer_pause_next = timer_pause_reg;
    busy_next        = busy_reg;

    if (coin_rise && !refund_tick) begin
      credit_next = (credit_reg == CREDIT_MAX) ? credit_reg : credit_reg + CREDIT_W'(1);
    end else if (!coin_rise && refund_tick) begin
      credit_next = credit_reg - CREDIT_W'(1);
    end

    case (state_reg)
      S_COLLECT: begin
        // Price, selector and busy are committed on entry so they are valid alongside coin_in.
        if (!wash_done && !refund_active && credit_reg >= price) begin
          state_next       = S_START;
          credit_next      = credit_reg - price + CREDIT_W'(coin_rise);
          double_wash_next = dbl_level;
          busy_next        = 1'b1;
        end
      end
      S_START: state_next = S_RUN;
      S_RUN: begin
        if (pause_rise) timer_pause_next = ~timer_pause_reg;
        if (wash_done) begin
          state_next       = S_DONE;
          busy_next        = 1'b0;
          double_wash_next = 1'b0;
          timer_pause_next = 1'b0;
        end
      end
      default: state_next = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_COLLECT;
      credit_reg      <= '0;
      double_wash_reg <= 1'b0;
      timer_pause_reg <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      credit_reg      <= credit_next;
      double_wash_reg <= double_wash_next;
      timer_pause_reg <= timer_pause_next;
      busy_reg        <= busy_next;
    end
  end

  assign coin_in     = (state_reg == S_START);
  assign double_wash = double_wash_reg;
  assign timer_pause = timer_pause_reg;
  assign credit      = credit_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_wash_panel_interface.sv
// Self-checking bench for wash_panel_interface with randomized switch timing
// against a credit/wash-count reference model.
module tb_wash_panel_interface;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_sw_raw = 1'b0;
  logic       double_sw_raw = 1'b0;
  logic       pause_btn_raw = 1'b0;
  logic       wash_done = 1'b0;
  logic       coin_in, double_wash, timer_pause, busy;
  logic [3:0] credit;
`ifdef REFUND_EN
  logic       refund_btn_raw = 1'b0;
  logic       coin_return;
`endif

  always #5 clk = ~clk;

  wash_panel_interface #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .coin_sw_raw(coin_sw_raw),
    .double_sw_raw(double_sw_raw),
    .pause_btn_raw(pause_btn_raw),
`ifdef REFUND_EN
    .refund_btn_raw(refund_btn_raw),
    .coin_return(coin_return),
`endif
    .wash_done(wash_done),
    .coin_in(coin_in),
    .double_wash(double_wash),
    .timer_pause(timer_pause),
    .credit(credit),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Start-pulse monitor, sampled on the falling edge.
  int         start_cnt = 0;
  int         pulse_len = 0;
  int         max_pulse = 0;
  logic [3:0] start_credit = 4'd0;
  logic       start_dw = 1'b0;
  logic       start_busy = 1'b0;

  always @(negedge clk) begin
    if (coin_in === 1'b1) begin
      if (pulse_len == 0) begin
        start_cnt    = start_cnt + 1;
        start_credit = credit;
        start_dw     = double_wash;
        start_busy   = busy;
      end
      pulse_len = pulse_len + 1;
      if (pulse_len > max_pulse) max_pulse = pulse_len;
    end else begin
      pulse_len = 0;
    end
  end

`ifdef REFUND_EN
  int cyc = 0, ret_cnt = 0, ret_last = 0, ret_bad_gap = 0;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (coin_return === 1'b1) begin
      if (ret_cnt > 0 && (cyc - ret_last) != 4) ret_bad_gap = ret_bad_gap + 1;
      ret_last = cyc;
      ret_cnt  = ret_cnt + 1;
    end
  end
`endif

  // Reference model: credit, washes started, latched selector, pause level.
  int m_credit = 0;
  int m_starts = 0;
  bit m_busy = 0, m_pause = 0, m_dbl = 0, m_dw = 0;

  function automatic int price_of();
    return m_dbl ? 3 : 2;
  endfunction

  function automatic void try_start(bit done_high);
    if (!m_busy && !done_high && m_credit >= price_of()) begin
      m_credit = m_credit - price_of();
      m_busy   = 1;
      m_starts = m_starts + 1;
      m_dw     = m_dbl;
    end
  endfunction

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic coin();
    coin_sw_raw = 1'b1;
    cycles(int'($urandom_range(8, 14)));
    coin_sw_raw = 1'b0;
    cycles(int'($urandom_range(8, 14)));
    m_credit = (m_credit < 15) ? m_credit + 1 : 15;
    try_start(wash_done);
  endtask

  task automatic pause_press();
    pause_btn_raw = 1'b1;
    cycles(int'($urandom_range(8, 12)));
    pause_btn_raw = 1'b0;
    cycles(10);
    if (m_busy) m_pause = ~m_pause;
  endtask

  task automatic set_dbl(bit v);
    double_sw_raw = v;
    cycles(10);
    m_dbl = v;
    try_start(wash_done);
  endtask

  task automatic end_wash(int hold);
    wash_done = 1'b1;
    cycles(hold);
    wash_done = 1'b0;
    m_busy  = 0;
    m_pause = 0;
    try_start(0);
    cycles(6);
  endtask

  task automatic test_reset();
    cycles(3);
    #1;
    checks++;
    if ({coin_in, double_wash, timer_pause, busy, credit} !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 00000000",
               {coin_in, double_wash, timer_pause, busy, credit});
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);
  endtask

  task automatic test_single_wash();
    coin();
    checks++;
    if (credit !== 4'd1) begin errors++; $display("FAIL t1_credit1: got %0d required 1", credit); end
    coin();
    checks++;
    if (start_cnt !== m_starts) begin errors++; $display("FAIL t1_start: got %0d required %0d", start_cnt, m_starts); end
    checks++;
    if (max_pulse !== 1) begin errors++; $display("FAIL t1_pulse_width: got %0d required 1", max_pulse); end
    checks++;
    if ({start_dw, start_busy, start_credit} !== {1'b0, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL t1_start_fields: got dw=%b busy=%b credit=%0d required dw=0 busy=1 credit=0",
               start_dw, start_busy, start_credit);
    end
    end_wash(2);
  endtask

  task automatic test_double();
    int s0;
    set_dbl(1'b1);
    s0 = start_cnt;
    coin();
    coin();
    checks++;
    if (start_cnt !== s0 || credit !== 4'd2) begin
      errors++;
      $display("FAIL t2_no_early_start: got starts=%0d credit=%0d required starts=%0d credit=2", start_cnt, credit, s0);
    end
    coin();
    checks++;
    if (start_cnt !== m_starts || start_dw !== 1'b1 || start_credit !== 4'd0) begin
      errors++;
      $display("FAIL t2_double_start: got starts=%0d dw=%b credit=%0d required starts=%0d dw=1 credit=0",
               start_cnt, start_dw, start_credit, m_starts);
    end
    end_wash(1);
    set_dbl(1'b0);
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 10; i++) begin
      coin_sw_raw = ~coin_sw_raw;
      cycles(2);
    end
    coin_sw_raw = 1'b1;
    cycles(12);
    coin_sw_raw = 1'b0;
    cycles(12);
    m_credit = m_credit + 1;
    try_start(0);
    checks++;
    if (credit !== 4'(m_credit)) begin errors++; $display("FAIL t3_bounce_credit: got %0d required %0d", credit, m_credit); end
  endtask

  task automatic test_pause();
    pause_press();
    checks++;
    if (timer_pause !== 1'b0) begin errors++; $display("FAIL t4_pause_idle: got %b required 0", timer_pause); end
    while (!m_busy) coin();
    for (int i = 0; i < 2; i++) begin
      pause_press();
      checks++;
      if (timer_pause !== m_pause) begin errors++; $display("FAIL t4_pause_%0d: got %b required %b", i, timer_pause, m_pause); end
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL t4_busy_before_done: got %b required 1", busy); end
    wash_done = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, double_wash, timer_pause} !== 3'b000) begin
      errors++;
      $display("FAIL t4_done_clear: got busy/dw/pause=%b required 000", {busy, double_wash, timer_pause});
    end
    @(negedge clk);
    wash_done = 1'b0;
    m_busy = 0;
    m_pause = 0;
    try_start(0);
    cycles(6);
  endtask

  task automatic test_coin_during_run();
    int s0;
    while (!m_busy) coin();
    coin();
    checks++;
    if (credit !== 4'(m_credit)) begin errors++; $display("FAIL t5_run_coin: got %0d required %0d", credit, m_credit); end
    wash_done = 1'b1;
    cycles(2);
    m_busy = 0;
    m_pause = 0;
    s0 = start_cnt;
    coin();
    checks++;
    if (start_cnt !== s0 || credit !== 4'(m_credit)) begin
      errors++;
      $display("FAIL t5_hold_while_done: got starts=%0d credit=%0d required starts=%0d credit=%0d",
               start_cnt, credit, s0, m_credit);
    end
    wash_done = 1'b0;
    try_start(0);
    cycles(6);
    checks++;
    if (start_cnt !== m_starts || credit !== 4'(m_credit)) begin
      errors++;
      $display("FAIL t5_restart: got starts=%0d credit=%0d required starts=%0d credit=%0d",
               start_cnt, credit, m_starts, m_credit);
    end
    for (int i = 0; i < 20; i++) coin();
    checks++;
    if (credit !== 4'd15) begin errors++; $display("FAIL t5_saturate: got %0d required 15", credit); end
    while (m_busy) end_wash(int'($urandom_range(1, 3)));
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      set_dbl(1'($urandom_range(0, 1)));
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) coin();
      checks++;
      if (credit !== 4'(m_credit) || start_cnt !== m_starts || busy !== m_busy) begin
        errors++;
        $display("FAIL rnd%0d_coins: got credit=%0d starts=%0d busy=%b required credit=%0d starts=%0d busy=%b",
                 it, credit, start_cnt, busy, m_credit, m_starts, m_busy);
      end
      if (m_busy) begin
        set_dbl(1'($urandom_range(0, 1)));
        for (int p = 0; p < int'($urandom_range(0, 3)); p++) pause_press();
        checks++;
        if (timer_pause !== m_pause || double_wash !== m_dw) begin
          errors++;
          $display("FAIL rnd%0d_run: got pause=%b dw=%b required pause=%b dw=%b",
                   it, timer_pause, double_wash, m_pause, m_dw);
        end
        end_wash(int'($urandom_range(1, 3)));
        checks++;
        if (credit !== 4'(m_credit) || start_cnt !== m_starts || busy !== m_busy) begin
          errors++;
          $display("FAIL rnd%0d_done: got credit=%0d starts=%0d busy=%b required credit=%0d starts=%0d busy=%b",
                   it, credit, start_cnt, busy, m_credit, m_starts, m_busy);
        end
      end
    end
  endtask

`ifdef REFUND_EN
  task automatic test_refund();
    while (m_busy) end_wash(2);
    wash_done = 1'b1;
    cycles(2);
    while (m_credit < 3) coin();
    ret_cnt = 0;
    ret_bad_gap = 0;
    refund_btn_raw = 1'b1;
    cycles(10);
    refund_btn_raw = 1'b0;
    cycles(25);
    m_credit = 0;
    checks++;
    if (ret_cnt !== 3 || ret_bad_gap !== 0 || credit !== 4'd0) begin
      errors++;
      $display("FAIL t6_refund: got pulses=%0d bad_gaps=%0d credit=%0d required 3 0 0", ret_cnt, ret_bad_gap, credit);
    end
    wash_done = 1'b0;
    cycles(4);
  endtask
`endif

  task automatic test_reset_midwash();
    set_dbl(1'b0);
    while (!m_busy) coin();
    pause_press();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({coin_in, double_wash, timer_pause, busy, credit} !== 8'd0) begin
      errors++;
      $display("FAIL t6_async_reset: got %b required 00000000",
               {coin_in, double_wash, timer_pause, busy, credit});
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_credit = 0; m_busy = 0; m_pause = 0;
    cycles(10);
    checks++;
    if (busy !== 1'b0 || credit !== 4'd0) begin
      errors++;
      $display("FAIL t6_after_reset: got busy=%b credit=%0d required 0 0", busy, credit);
    end
  endtask

  initial begin
    test_reset();
    test_single_wash();
    test_double();
    test_bounce();
    test_pause();
    test_coin_during_run();
    test_random();
`ifdef REFUND_EN
    test_refund();
`endif
    test_reset_midwash();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish within 2 ms");
    $fatal(1);
  end

endmodule
